// File: rtl/imem_port_arbiter.sv
// Arbitrates the single instruction-ROM read port between IF fetch (port 0) and DBG (port 1).
// Define IMEM_RR_ARB_EN for round-robin arbitration instead of fixed IF priority with a starvation guard.
module imem_port_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              starved
);

   logic if_win;
   logic dbg_win;

`ifdef IMEM_RR_ARB_EN
   // prio_dbg set means IF was granted most recently, so DBG wins the next tie
   logic prio_dbg;

   // Round-robin winner selection
   always_comb begin
      if_win  = 1'b0;
      dbg_win = 1'b0;
      if (if_req && dbg_req) begin
         if_win  = ~prio_dbg;
         dbg_win = prio_dbg;
      end else begin
         if_win  = if_req;
         dbg_win = dbg_req;
      end
   end

   // Pointer follows every grant
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_dbg <= 1'b0;
      end else if (if_win) begin
         prio_dbg <= 1'b1;
      end else if (dbg_win) begin
         prio_dbg <= 1'b0;
      end else begin
         prio_dbg <= prio_dbg;
      end
   end

   assign starved = 1'b0;
`else
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(STARVE_LIMIT - 1);
   localparam logic [0:0] ST_NORMAL = 1'b0;
   localparam logic [0:0] ST_BOOST  = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   // Fixed IF priority; one cycle of DBG priority after STARVE_LIMIT consecutive denials
   always_comb begin
      if_win    = 1'b0;
      dbg_win   = 1'b0;
      state_nxt = ST_NORMAL;
      cnt_nxt   = '0;
      case (state)
         ST_BOOST: begin
            dbg_win   = dbg_req;
            if_win    = if_req & ~dbg_req;
            state_nxt = ST_NORMAL;
            cnt_nxt   = '0;
         end
         ST_NORMAL: begin
            if_win  = if_req;
            dbg_win = dbg_req & ~if_req;
            if (dbg_req && !dbg_win) begin
               cnt_nxt   = sat_inc(cnt);
               state_nxt = (cnt == CNT_TRIG) ? ST_BOOST : ST_NORMAL;
            end else begin
               cnt_nxt   = '0;
               state_nxt = ST_NORMAL;
            end
         end
         default: begin
            if_win    = 1'b0;
            dbg_win   = 1'b0;
            state_nxt = ST_NORMAL;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Starvation FSM state and deny counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_NORMAL;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign starved = (state == ST_BOOST);
`endif

   assign if_gnt  = if_win;
   assign dbg_gnt = dbg_win;

   // ROM address follows the winner; parked at zero when idle
   always_comb begin
      mem_addr = '0;
      if (if_win) begin
         mem_addr = if_addr;
      end else if (dbg_win) begin
         mem_addr = dbg_addr;
      end else begin
         mem_addr = '0;
      end
   end

   // Read-data return; rdata holds its last word between reads
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if_rvalid  <= 1'b0;
         dbg_rvalid <= 1'b0;
         if_rdata   <= '0;
         dbg_rdata  <= '0;
      end else begin
         if_rvalid  <= if_win;
         dbg_rvalid <= dbg_win;
         if (if_win) begin
            if_rdata <= mem_data;
         end
         if (dbg_win) begin
            dbg_rdata <= mem_data;
         end
      end
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized bench for imem_port_arbiter against a streak-counting reference model.
// Honors IMEM_RR_ARB_EN to select the round-robin reference.
module tb_imem_port_arbiter;
   localparam int AW  = 10;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, dbg_req;
   logic [AW-1:0] if_addr, dbg_addr;
   logic          if_gnt, dbg_gnt, if_rvalid, dbg_rvalid, starved;
   logic [DW-1:0] if_rdata, dbg_rdata, mem_data;
   logic [AW-1:0] mem_addr;

   logic [DW-1:0] rom [0:1023];

   imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
      .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_data(mem_data), .starved(starved)
   );

   always #5 clk = ~clk;
   assign mem_data = rom[mem_addr];

   int checks = 0;
   int errors = 0;

   // Reference model: consecutive-denial streak, last-granted port, expected returns
   int            streak = 0;
   bit            last_if = 1'b0;
   bit            ei, ed;
   bit            first = 1'b1;
   bit            exp_if_rv = 1'b0, exp_dbg_rv = 1'b0;
   logic [DW-1:0] exp_if_rd = '0, exp_dbg_rd = '0;
   int            dbg_grants = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: check comb outputs, clock, advance model, check registered outputs
   task automatic cycle(input bit r);
      logic [AW-1:0] exp_addr;
      rst_n = r;
      #1;
`ifdef IMEM_RR_ARB_EN
      ei = if_req && (!dbg_req || !last_if);
      ed = dbg_req && !ei;
`else
      if (streak >= LIM) begin
         ed = dbg_req;
         ei = if_req && !dbg_req;
      end else begin
         ei = if_req;
         ed = dbg_req && !if_req;
      end
`endif
      exp_addr = ei ? if_addr : (ed ? dbg_addr : '0);
      if (!first) begin
         check("if_gnt", 64'(if_gnt), 64'(ei));
         check("dbg_gnt", 64'(dbg_gnt), 64'(ed));
         check("mem_addr", 64'(mem_addr), 64'(exp_addr));
      end
      first = 1'b0;
      @(posedge clk);
      if (!r) begin
         streak = 0; last_if = 1'b0;
         exp_if_rv = 1'b0; exp_dbg_rv = 1'b0; exp_if_rd = '0; exp_dbg_rd = '0;
      end else begin
         exp_if_rv  = ei;
         exp_dbg_rv = ed;
         if (ei) exp_if_rd = rom[if_addr];
         if (ed) begin exp_dbg_rd = rom[dbg_addr]; dbg_grants++; end
         streak = (dbg_req && !ed) ? streak + 1 : 0;
         if (ei) last_if = 1'b1;
         else if (ed) last_if = 1'b0;
      end
      #1;
      check("if_rvalid", 64'(if_rvalid), 64'(exp_if_rv));
      check("dbg_rvalid", 64'(dbg_rvalid), 64'(exp_dbg_rv));
      check("if_rdata", 64'(if_rdata), 64'(exp_if_rd));
      check("dbg_rdata", 64'(dbg_rdata), 64'(exp_dbg_rd));
`ifdef IMEM_RR_ARB_EN
      check("starved", 64'(starved), 64'd0);
`else
      check("starved", 64'(starved), 64'(streak >= LIM));
`endif
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = $urandom;
      rom[10'h011] = 32'h0c000cf8;
      if_req = 1'b1; dbg_req = 1'b0; if_addr = 10'h011; dbg_addr = 10'h000;

      // T1: reset with if_req asserted
      cycle(1'b0);
      cycle(1'b0);
      check("t1_if_rvalid", 64'(if_rvalid), 64'd0);
      check("t1_if_rdata", 64'(if_rdata), 64'd0);

      // T2: single IF read
      if_req = 1'b1; if_addr = 10'h011;
      cycle(1'b1);
      check("t2_if_rdata", 64'(if_rdata), 64'h0c000cf8);
      if_req = 1'b0;
      cycle(1'b1);
      check("t2_rdata_hold", 64'(if_rdata), 64'h0c000cf8);

      // T3/T4: continuous contention
      dbg_grants = 0;
      if_req = 1'b1; dbg_req = 1'b1; if_addr = 10'h020; dbg_addr = 10'h3f0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1);
         if_addr = if_addr + 10'd1;
      end
`ifdef IMEM_RR_ARB_EN
      check("t4_dbg_grants", 64'(dbg_grants), 64'd5);
`else
      check("t3_dbg_grants", 64'(dbg_grants), 64'd2);
`endif

      // T5: keep contending until BOOST, then drop dbg_req
      for (int i = 0; i < 8 && !(streak >= LIM); i++) cycle(1'b1);
      dbg_req = 1'b0;
      cycle(1'b1);
      check("t5_streak_clear", 64'(streak), 64'd0);

      // T6: DBG granted in the cycle whose closing edge samples reset
      if_req = 1'b0; dbg_req = 1'b1; dbg_addr = 10'h155;
      cycle(1'b1);
      dbg_addr = 10'h2aa;
      cycle(1'b0);
      check("t6_dbg_rvalid", 64'(dbg_rvalid), 64'd0);
      check("t6_dbg_rdata", 64'(dbg_rdata), 64'd0);
      dbg_req = 1'b0;
      cycle(1'b1);

      // Random traffic; a denied requester holds req and addr
      for (int i = 0; i < 600; i++) begin
         bit hold_if, hold_dbg;
         hold_if  = if_req && !ei && rst_n;
         hold_dbg = dbg_req && !ed && rst_n;
         if (!hold_if) begin
            if_req  = ($urandom_range(0, 99) < 70);
            if_addr = AW'($urandom);
         end
         if (!hold_dbg) begin
            dbg_req  = ($urandom_range(0, 99) < 60);
            dbg_addr = AW'($urandom);
         end
         cycle(($urandom_range(0, 79) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
